fb_write_arbiter: RTL

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter
// Brief    : Single-port framebuffer write arbiter. A streaming frame loader
//            and a cursor painter share the BRAM write port. Round-robin
//            arbitration applies on contention, and all writes are registered.
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    input  logic        paint_req,
    input  logic [9:0]  paint_x,
    input  logic [9:0]  paint_y,
    input  logic [2:0]  paint_color,
    output logic        paint_ack,
    output logic        paint_err,
    output logic        bram_we,
    output logic [18:0] bram_waddr,
    output logic [7:0]  bram_wdata,
    output logic        load_active,
    output logic        load_done,
    output logic [18:0] pixel_count
);

    localparam logic [0:0]  S_IDLE     = 1'b0;
    localparam logic [0:0]  S_LOAD     = 1'b1;
    localparam logic [9:0]  c_H_RES    = 10'(H_RES);
    localparam logic [9:0]  c_V_RES    = 10'(V_RES);
    localparam logic [18:0] c_LAST_PIX = 19'(H_RES * V_RES - 1);

    logic [0:0]  r_state;
    logic [18:0] r_count;
    logic        r_last_grant;   // 1: last contended grant went to paint
    logic        r_we;
    logic [18:0] r_waddr;
    logic [7:0]  r_wdata;
    logic        r_ack;
    logic        r_err;
    logic        r_done;

    logic        w_paint_ok;
    logic        w_contend;
    logic        w_paint_grant;
    logic        w_load_acc;
    logic        w_paint_oor;
    logic [18:0] w_paint_addr;
    logic [18:0] w_y_ext;
    logic        w_last_byte;

    // A held paint request is not re-accepted while its ack is still showing.
    assign w_paint_ok    = paint_req && !r_ack;
    // Contention exists only when the loader could otherwise take the port.
    assign w_contend     = (r_state == S_LOAD) && !load_start && load_valid && w_paint_ok;
    assign w_paint_grant = w_contend ? !r_last_grant : w_paint_ok;
    assign load_ready    = !reset && (r_state == S_LOAD) && !load_start && !w_paint_grant;
    assign w_load_acc    = load_valid && load_ready;

    assign w_paint_oor   = (paint_x >= c_H_RES) || (paint_y >= c_V_RES);
    // y*640 as shift-add, carried at full address width to avoid truncation.
    assign w_y_ext       = {9'd0, paint_y};
    assign w_paint_addr  = (w_y_ext << 9) + (w_y_ext << 7) + {9'd0, paint_x};
    assign w_last_byte   = (r_count == c_LAST_PIX);

    // Load FSM, arbitration history and registered write/handshake outputs
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_ack  <= w_paint_grant;
            r_err  <= w_paint_grant && w_paint_oor;

            if (w_contend) begin
                r_last_grant <= w_paint_grant;
            end

            if (w_paint_grant && !w_paint_oor) begin
                r_we    <= 1'b1;
                r_waddr <= w_paint_addr;
                r_wdata <= {5'b0, paint_color};
            end

            if (w_load_acc) begin
                r_we    <= 1'b1;
                r_waddr <= r_count;
                r_wdata <= {5'b0, load_data[2:0]};
            end

            if (load_start) begin
                r_state <= S_LOAD;
                r_count <= '0;
            end else if (w_load_acc) begin
                r_count <= r_count + 19'd1;
                if (w_last_byte) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bram_we     = r_we;
    assign bram_waddr  = r_waddr;
    assign bram_wdata  = r_wdata;
    assign paint_ack   = r_ack;
    assign paint_err   = r_err;
    assign load_done   = r_done;
    assign load_active = (r_state == S_LOAD);
    assign pixel_count = r_count;

endmodule
`default_nettype wire
